sprite_anim_renderer: RTL and testbench
=======================================

# sprite_anim_renderer

Parametrised, pipelined sprite renderer for the VGA overlay path. It draws a multi-frame sprite, such as the bow draw animation, at a runtime position with power-of-two scaling and two transparent palette indices. A charge/fire state machine steps through the animation frames once per video frame. It sits between the VGA controller (DrawX/DrawY/blank) and the layer compositor, and drives an external synchronous sprite ROM and a combinational palette.

## Interface
- SPR_W, 108, sprite width in source pixels
- SPR_H, 187, sprite height in source pixels
- FRAMES, 4, animation frames stored back-to-back in ROM (frame f base = f*SPR_W*SPR_H)
- SCALE_SHIFT, 1, on-screen scale = 2^SCALE_SHIFT per axis
- IDX_W, 3, palette index width
- ADDR_W, 17, ROM address width; must satisfy 2^ADDR_W >= FRAMES*SPR_W*SPR_H
- TRANS_A, 0 and TRANS_B, 6, transparent palette indices
- STEP_FRAMES, 8, video frames per animation step while charging
- POS_X0, 409 and POS_Y0, 106, reset position
- Clocking and reset: one clock; reset is asynchronous and active-low.
- vga_clk  in  1  pixel clock; all logic on posedge
- reset_n  in  1  asynchronous active-low reset
- DrawX, DrawY  in  10 each  current pixel coordinates
- blank  in  1  1 = active display region
- pos_x, pos_y  in  10 each  requested top-left screen position
- draw_req  in  1  level; high = bow held (charging)
- rom_addr  out  ADDR_W  registered ROM address
- rom_q  in  IDX_W  ROM data, valid one cycle after rom_addr
- pal_idx  out  IDX_W  palette lookup index (= rom_q)
- pal_r, pal_g, pal_b  in  4 each  combinational palette colour for pal_idx
- red, green, blue  out  4 each  registered pixel colour
- a  out  1  registered opacity (1 = sprite pixel drawn)
- frame_idx  out  clog2(FRAMES)  current animation frame
- fire  out  1  one-cycle pulse on release
- fire_power  out  clog2(FRAMES)  frame index at release; valid with fire

## Operation
- Frame tick: DrawX==0 && DrawY==0. On a tick, pos_x/pos_y are latched into px/py. Position is never updated mid-frame.
- Window, in 11-bit arithmetic: px <= DrawX < px+(SPR_W<<SCALE_SHIFT) and py <= DrawY < py+(SPR_H<<SCALE_SHIFT). A window extending past 639/479 is clipped naturally.
- Address: ((DrawY-py)>>SCALE_SHIFT)*SPR_W + ((DrawX-px)>>SCALE_SHIFT) + frame_idx*SPR_W*SPR_H. Outside the window the address is 0.
- Stage 0 (comb) computes in_win and the address. Stage 1 registers rom_addr, in_win and blank. Stage 2: rom_q valid, sidebands registered again. Stage 3: output registers.
- Output: if the delayed blank=0, then rgb=0 and a=0. Otherwise rgb=palette colour, and a = in_win && rom_q != TRANS_A && rom_q != TRANS_B.
- FSM states:
  - IDLE: frame 0. Goes to CHARGE when draw_req=1.
  - CHARGE: a step counter counts ticks. After STEP_FRAMES ticks, frame_idx increments, saturating at FRAMES-1 (full draw). Goes to FIRE when draw_req=0.
  - FIRE: one cycle. fire=1, fire_power=frame_idx. Next state IDLE with frame_idx=0 and step counter cleared.
- draw_req is sampled every cycle, not only on ticks. A release before the first step fires with power 0.
- frame_idx changes only on a tick or on entry to IDLE. The IDLE reset to frame 0 happens at a FIRE cycle, which may fall mid-frame; a tear on that single frame is acceptable.

## Timing
- Latency: DrawX/DrawY/blank to red/green/blue/a is 3 cycles exactly, with no bubbles; one pixel per cycle sustained.
- rom_addr is presented 1 cycle after the DrawX it belongs to.
- Reset (async assert, sync-safe deassert) sets:
  - red/green/blue=0, a=0, rom_addr=0, fire=0, fire_power=0, frame_idx=0
  - state IDLE, step counter 0, px=POS_X0, py=POS_Y0, pipeline sidebands 0
- Reset asserted mid-frame: outputs go to 0 immediately. The first valid pixel appears 3 cycles after deassert. Position stays at the POS_X0/POS_Y0 defaults until the next tick.
- fire is high for exactly 1 cycle per release; a reassert of draw_req in the FIRE cycle is honoured from IDLE on the next cycle.
- Step counter width: clog2(STEP_FRAMES+1). Counting stops at saturation, so there is no wrap.

## Test plan
- Reset defaults: pos_x=409, pos_y=106, SCALE_SHIFT=1. Pixel (409,106) → rom_addr=0 one cycle later. (411,108) → rom_addr=109. (408,106) and (625,106) → a=0.
- Latency/transparency: ROM model with rom_q=6 at address 0 and 3 at address 1. Output at pixel (409,106) has a=0; at (411,106), 3 cycles later, a=1 with the palette colour. With blank=0, rgb=0.
- Position latch: change pos_x to 100 mid-frame → the current frame still uses 409; after the next tick, pixel (100,106) → address 0.
- Charge: draw_req=1 for 40 ticks (STEP_FRAMES=8) → frame_idx steps 1,2,3 at ticks 8,16,24 and stays 3. The address for pixel (409,106) is then 3*20196=60588.
- Release: drop draw_req after 10 ticks → fire pulses 1 cycle with fire_power=1, then frame_idx=0. Drop before tick 8 → fire_power=0.
- Async reset: assert reset_n=0 during CHARGE mid-line → all outputs 0 immediately, FSM IDLE, no fire pulse.

Source files
------------

// File: rtl/sprite_anim_renderer.sv
// Pipelined multi-frame sprite renderer with scaling, two transparent indices and a
// charge/fire animation FSM. DrawX/DrawY/blank to red/green/blue/a is 3 cycles.
`timescale 1ns/1ps
module sprite_anim_renderer #(
  parameter int unsigned SPR_W       = 108,
  parameter int unsigned SPR_H       = 187,
  parameter int unsigned FRAMES      = 4,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned IDX_W       = 3,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned TRANS_A     = 0,
  parameter int unsigned TRANS_B     = 6,
  parameter int unsigned STEP_FRAMES = 8,
  parameter int unsigned POS_X0      = 409,
  parameter int unsigned POS_Y0      = 106,
  localparam int unsigned FW = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int unsigned CW = $clog2(STEP_FRAMES + 1)
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              draw_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_idx,
  input  logic [3:0]        pal_r,
  input  logic [3:0]        pal_g,
  input  logic [3:0]        pal_b,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              a,
  output logic [FW-1:0]     frame_idx,
  output logic              fire,
  output logic [FW-1:0]     fire_power
);

  typedef enum logic [1:0] {StIdle, StCharge, StFire} state_t;

  state_t          state;
  logic [CW-1:0]   step_cnt;
  logic [9:0]      px, py;
  logic            tick;
  logic [10:0]     dx, dy;
  logic            in_win;
  logic [ADDR_W-1:0] addr;
  logic            win1, win2, blank1, blank2;
  logic            opaque;

  assign tick = (DrawX == 10'd0) && (DrawY == 10'd0);

  // Stage 0: window test and address, all in 11 bits so the window end never wraps.
  assign dx = {1'b0, DrawX} - {1'b0, px};
  assign dy = {1'b0, DrawY} - {1'b0, py};
  assign in_win = ({1'b0, DrawX} >= {1'b0, px}) &&
                  ({1'b0, DrawX} <  {1'b0, px} + 11'(SPR_W << SCALE_SHIFT)) &&
                  ({1'b0, DrawY} >= {1'b0, py}) &&
                  ({1'b0, DrawY} <  {1'b0, py} + 11'(SPR_H << SCALE_SHIFT));
  assign addr = ADDR_W'(dy >> SCALE_SHIFT) * ADDR_W'(SPR_W) + ADDR_W'(dx >> SCALE_SHIFT) +
                ADDR_W'(frame_idx) * ADDR_W'(SPR_W * SPR_H);

  assign pal_idx = rom_q;
  assign opaque  = (rom_q != IDX_W'(TRANS_A)) && (rom_q != IDX_W'(TRANS_B));

  // Position only moves at the frame tick so a frame is never drawn at two places.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      px <= 10'(POS_X0);
      py <= 10'(POS_Y0);
    end else if (tick) begin
      px <= pos_x;
      py <= pos_y;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr <= '0;
      win1     <= 1'b0;
      blank1   <= 1'b0;
      win2     <= 1'b0;
      blank2   <= 1'b0;
      red      <= 4'd0;
      green    <= 4'd0;
      blue     <= 4'd0;
      a        <= 1'b0;
    end else begin
      rom_addr <= in_win ? addr : '0;
      win1     <= in_win;
      blank1   <= blank;
      win2     <= win1;
      blank2   <= blank1;
      red      <= blank2 ? pal_r : 4'd0;
      green    <= blank2 ? pal_g : 4'd0;
      blue     <= blank2 ? pal_b : 4'd0;
      a        <= blank2 && win2 && opaque;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= StIdle;
      step_cnt   <= '0;
      frame_idx  <= '0;
      fire       <= 1'b0;
      fire_power <= '0;
    end else begin
      fire <= 1'b0;
      case (state)
        StIdle: begin
          if (draw_req) state <= StCharge;
        end
        StCharge: begin
          if (!draw_req) begin
            state      <= StFire;
            fire       <= 1'b1;
            fire_power <= frame_idx;
          end else if (tick) begin
            // Once the last frame is reached the counter parks at STEP_FRAMES.
            if (step_cnt == CW'(STEP_FRAMES - 1) && frame_idx != FW'(FRAMES - 1)) begin
              frame_idx <= frame_idx + FW'(1);
              step_cnt  <= '0;
            end else if (step_cnt != CW'(STEP_FRAMES)) begin
              step_cnt <= step_cnt + CW'(1);
            end
          end
        end
        StFire: begin
          state     <= StIdle;
          frame_idx <= '0;
          step_cnt  <= '0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Bench for sprite_anim_renderer: vector table, directed FSM sequences and random pixels
// checked against a cycle-level reference model.
`timescale 1ns/1ps
module tb_sprite_anim_renderer;
  localparam int SPR_W = 108, SPR_H = 187, FRAMES = 4, SHIFT = 1, STEP = 8;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY, pos_x, pos_y;
  logic        blank, draw_req;
  logic [16:0] rom_addr;
  logic [2:0]  rom_q, pal_idx;
  logic [3:0]  pal_r, pal_g, pal_b, red, green, blue;
  logic        a, fire;
  logic [1:0]  frame_idx, fire_power;

  sprite_anim_renderer dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .draw_req(draw_req), .rom_addr(rom_addr), .rom_q(rom_q),
    .pal_idx(pal_idx), .pal_r(pal_r), .pal_g(pal_g), .pal_b(pal_b), .red(red),
    .green(green), .blue(blue), .a(a), .frame_idx(frame_idx), .fire(fire),
    .fire_power(fire_power)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic logic [2:0] rom_fn(input int addr);
    if (addr == 0) return 3'd6;
    if (addr == 1) return 3'd3;
    return 3'(addr ^ (addr >> 3) ^ (addr >> 7));
  endfunction

  function automatic logic [11:0] pal_fn(input logic [2:0] i);
    return {i, 1'b1, 1'b1, ~i, i[0], i};
  endfunction

  always @(posedge vga_clk) rom_q <= rom_fn(int'(rom_addr));
  assign {pal_r, pal_g, pal_b} = pal_fn(pal_idx);

  typedef struct {
    logic [11:0] rgb;
    logic        a;
    int          tbl_a;
  } pix_t;

  typedef struct {
    int   x;
    int   y;
    logic bl;
    int   addr;
    int   a;
  } vec_t;

  int   checks = 0, failures = 0;
  int   m_px, m_py, m_phase, m_ticks, m_power;  // phase: 0 idle, 1 charging, 2 firing
  pix_t q[$];
  vec_t tbl[11];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_frame();
    int f;
    if (m_phase == 0) return 0;
    f = m_ticks / STEP;
    return (f > FRAMES - 1) ? FRAMES - 1 : f;
  endfunction

  task automatic model_reset();
    pix_t z;
    m_px = 409; m_py = 106; m_phase = 0; m_ticks = 0; m_power = 0;
    z.rgb = '0; z.a = 1'b0; z.tbl_a = -1;
    q.delete();
    q.push_back(z);
    q.push_back(z);
  endtask

  // One pixel per call; inputs applied just after a rising edge, outputs checked 1ns after the next.
  task automatic cycle(input int x, input int y, input logic bl, input int tbl_a = -1);
    pix_t    e;
    pix_t    got;
    int      adr, fr;
    bit      inw, tk;
    logic [2:0] idx;
    DrawX = 10'(x); DrawY = 10'(y); blank = bl;
    fr  = m_frame();
    inw = x >= m_px && x < m_px + (SPR_W << SHIFT) && y >= m_py && y < m_py + (SPR_H << SHIFT);
    adr = inw ? ((y - m_py) >> SHIFT) * SPR_W + ((x - m_px) >> SHIFT) + fr * SPR_W * SPR_H : 0;
    idx = rom_fn(adr);
    e.rgb = bl ? pal_fn(idx) : 12'd0;
    e.a = bl && inw && idx != 3'd0 && idx != 3'd6;
    e.tbl_a = tbl_a;
    q.push_back(e);
    tk = (x == 0 && y == 0);
    @(posedge vga_clk);
    if (tk) begin
      m_px = int'(pos_x);
      m_py = int'(pos_y);
    end
    case (m_phase)
      0: if (draw_req) begin m_phase = 1; m_ticks = 0; end
      1: if (!draw_req) begin m_power = m_frame(); m_phase = 2; end
         else if (tk) m_ticks++;
      default: begin m_phase = 0; m_ticks = 0; end
    endcase
    #1;
    check("rom_addr", int'(rom_addr), adr);
    check("frame_idx", int'(frame_idx), m_frame());
    check("fire", int'(fire), int'(m_phase == 2));
    check("fire_power", int'(fire_power), m_power);
    got = q.pop_front();
    check("rgb", int'({red, green, blue}), int'(got.rgb));
    check("a", int'(a), int'(got.a));
    if (got.tbl_a >= 0) check("table_a", int'(a), got.tbl_a);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_rgb"}, int'({red, green, blue}), 0);
    check({name, "_a"}, int'(a), 0);
    check({name, "_rom_addr"}, int'(rom_addr), 0);
    check({name, "_frame"}, int'(frame_idx), 0);
    check({name, "_fire"}, int'(fire), 0);
    check({name, "_power"}, int'(fire_power), 0);
  endtask

  task automatic apply_reset();
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    draw_req = 1'b0;
    model_reset();
    @(posedge vga_clk);
    @(posedge vga_clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; DrawX = 10'd5; DrawY = 10'd5; blank = 1'b0;
    pos_x = 10'd409; pos_y = 10'd106; draw_req = 1'b0;
    #1 check_all_zero("reset");
    model_reset();
    @(posedge vga_clk);
    @(posedge vga_clk);
    #1 reset_n = 1'b1;

    tbl[0]  = '{x: 409, y: 106, bl: 1'b1, addr: 0,     a: 0};
    tbl[1]  = '{x: 411, y: 108, bl: 1'b1, addr: 109,   a: -1};
    tbl[2]  = '{x: 411, y: 106, bl: 1'b1, addr: 1,     a: 1};
    tbl[3]  = '{x: 408, y: 106, bl: 1'b1, addr: 0,     a: 0};
    tbl[4]  = '{x: 625, y: 106, bl: 1'b1, addr: 0,     a: 0};
    tbl[5]  = '{x: 624, y: 106, bl: 1'b1, addr: 107,   a: -1};
    tbl[6]  = '{x: 409, y: 479, bl: 1'b1, addr: 20088, a: -1};
    tbl[7]  = '{x: 409, y: 480, bl: 1'b1, addr: 0,     a: 0};
    tbl[8]  = '{x: 411, y: 106, bl: 1'b0, addr: 1,     a: 0};
    tbl[9]  = '{x: 410, y: 107, bl: 1'b1, addr: 0,     a: 0};
    tbl[10] = '{x: 409, y: 105, bl: 1'b1, addr: 0,     a: 0};
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].x, tbl[i].y, tbl[i].bl, tbl[i].a);
      check("table_addr", int'(rom_addr), tbl[i].addr);
    end
    for (int i = 0; i < 3; i++) cycle(5, 5, 1'b0);

    // Position latch: mid-frame change must wait for the tick.
    pos_x = 10'd100;
    cycle(411, 108, 1'b1);
    check("latch_old_pos", int'(rom_addr), 109);
    cycle(0, 0, 1'b1);
    cycle(100, 106, 1'b1);
    check("latch_new_pos0", int'(rom_addr), 0);
    cycle(102, 106, 1'b1);
    check("latch_new_pos1", int'(rom_addr), 1);
    pos_x = 10'd409;
    cycle(0, 0, 1'b1);

    // Full charge: steps at ticks 8, 16, 24 then saturates.
    draw_req = 1'b1;
    cycle(5, 5, 1'b1);
    for (int t = 1; t <= 40; t++) begin
      cycle(0, 0, 1'b1);
      cycle(420 + t, 110 + t, 1'b1);
      if (t == 7)  check("charge_t7", int'(frame_idx), 0);
      if (t == 8)  check("charge_t8", int'(frame_idx), 1);
      if (t == 16) check("charge_t16", int'(frame_idx), 2);
      if (t == 24) check("charge_t24", int'(frame_idx), 3);
      if (t == 40) check("charge_t40", int'(frame_idx), 3);
    end
    cycle(409, 106, 1'b1);
    check("charged_addr", int'(rom_addr), 60588);
    draw_req = 1'b0;
    cycle(5, 5, 1'b1);
    check("full_fire", int'(fire), 1);
    check("full_fire_power", int'(fire_power), 3);
    cycle(5, 5, 1'b1);
    check("full_fire_end", int'(fire), 0);
    check("full_frame_rst", int'(frame_idx), 0);

    // Release after 10 ticks, then release before the first step.
    draw_req = 1'b1;
    cycle(5, 5, 1'b1);
    for (int t = 0; t < 10; t++) begin cycle(0, 0, 1'b1); cycle(430, 120, 1'b1); end
    draw_req = 1'b0;
    cycle(5, 5, 1'b1);
    check("rel10_fire", int'(fire), 1);
    check("rel10_power", int'(fire_power), 1);
    draw_req = 1'b1;  // reassert during the fire cycle
    cycle(5, 5, 1'b1);
    check("rel10_fire_end", int'(fire), 0);
    check("rel10_frame_rst", int'(frame_idx), 0);
    for (int t = 0; t < 3; t++) cycle(0, 0, 1'b1);
    draw_req = 1'b0;
    cycle(5, 5, 1'b1);
    check("early_fire", int'(fire), 1);
    check("early_power", int'(fire_power), 0);
    cycle(5, 5, 1'b1);

    // Async reset mid-line while charging; position falls back to defaults.
    draw_req = 1'b1;
    cycle(5, 5, 1'b1);
    for (int t = 0; t < 9; t++) begin cycle(0, 0, 1'b1); cycle(440, 130, 1'b1); end
    pos_x = 10'd50;
    for (int i = 0; i < 4; i++) cycle(450 + i, 140, 1'b1);
    apply_reset();
    for (int i = 0; i < 4; i++) cycle(411 + i, 108, 1'b1);
    check("post_reset_fire", int'(fire), 0);
    check("post_reset_frame", int'(frame_idx), 0);
    pos_x = 10'd409;
    cycle(0, 0, 1'b1);

    // Random pixels, ticks, positions and draw_req against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199, 0) == 0) draw_req = ~draw_req;
      if ($urandom_range(499, 0) == 0) begin
        pos_x = 10'($urandom_range(500, 300));
        pos_y = 10'($urandom_range(200, 50));
      end
      if ($urandom_range(39, 0) == 0) cycle(0, 0, 1'b1);
      else cycle($urandom_range(660, 280), $urandom_range(500, 40), $urandom_range(9, 0) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
